// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 64-bit, 4-beat burst interface: programmable
// access latency in front of a line-organised backing store.
module burst_mem_responder #(
  parameter int unsigned LATENCY  = 4,
  parameter int unsigned IDX_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic        mem_resp,
  output logic [63:0] mem_rdata,
  output logic        busy,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned LINES  = 1 << IDX_BITS;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned LAT_W  = 8;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t                         state, state_d;
  logic [LAT_W-1:0]               lat_cnt, lat_cnt_d;
  logic [1:0]                     beat, beat_d;
  logic [IDX_BITS-1:0]            line, line_d;
  logic                           is_wr, is_wr_d;
  logic                           resp_d;
  logic                           busy_d;
  logic [BEAT_W-1:0]              rdata_d;
  logic [CNT_W-1:0]               rd_count_d, wr_count_d;

  logic [BEATS-1:0][BEAT_W-1:0]   store [LINES];

  // Offset and aliased upper address bits are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^{mem_addr[31:5+IDX_BITS], mem_addr[4:0]};

  // Next-state and next-output logic; outputs are registered so the beat
  // data for cycle n+1 is looked up with the next-cycle line/beat.
  always_comb begin
    state_d    = state;
    lat_cnt_d  = lat_cnt;
    beat_d     = beat;
    line_d     = line;
    is_wr_d    = is_wr;
    rd_count_d = rd_count;
    wr_count_d = wr_count;

    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          line_d  = mem_addr[4+IDX_BITS:5];
          is_wr_d = !mem_read;
          beat_d  = 2'd0;
          if (LATENCY == 1) begin
            state_d = BURST;
          end else begin
            state_d   = WAIT;
            lat_cnt_d = LAT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (lat_cnt == LAT_W'(1)) begin
          state_d   = BURST;
          lat_cnt_d = '0;
          beat_d    = 2'd0;
        end else begin
          lat_cnt_d = lat_cnt - LAT_W'(1);
        end
      end
      BURST: begin
        if (beat == 2'd3) begin
          state_d = TURN;
          beat_d  = 2'd0;
          if (is_wr) wr_count_d = wr_count + CNT_W'(1);
          else       rd_count_d = rd_count + CNT_W'(1);
        end else begin
          beat_d = beat + 2'd1;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    resp_d  = (state_d == BURST);
    busy_d  = (state_d != IDLE);
    rdata_d = (resp_d && !is_wr_d) ? store[line_d][beat_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      beat      <= '0;
      line      <= '0;
      is_wr     <= 1'b0;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      busy      <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      state     <= state_d;
      lat_cnt   <= lat_cnt_d;
      beat      <= beat_d;
      line      <= line_d;
      is_wr     <= is_wr_d;
      mem_resp  <= resp_d;
      mem_rdata <= rdata_d;
      busy      <= busy_d;
      rd_count  <= rd_count_d;
      wr_count  <= wr_count_d;
    end
  end

  // Store is never cleared; a reset aborts any remaining write beats.
  always_ff @(posedge clk) begin
    if (!rst && state == BURST && is_wr) begin
      store[line][beat] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: timing, data, aliasing, arbitration,
// late request drop, latency extremes and reset during a write burst.
module tb_burst_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;

  logic        resp4, resp1, resp255;
  logic [63:0] rdata4, rdata1, rdata255;
  logic        busy4, busy1, busy255;
  logic [31:0] rdc4, rdc1, rdc255, wrc4, wrc1, wrc255;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  burst_mem_responder #(.LATENCY(4), .IDX_BITS(8)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp(resp4),
    .mem_rdata(rdata4), .busy(busy4), .rd_count(rdc4), .wr_count(wrc4));

  burst_mem_responder #(.LATENCY(1), .IDX_BITS(8)) dut_lat1 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp(resp1),
    .mem_rdata(rdata1), .busy(busy1), .rd_count(rdc1), .wr_count(wrc1));

  burst_mem_responder #(.LATENCY(255), .IDX_BITS(8)) dut_lat255 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp(resp255),
    .mem_rdata(rdata255), .busy(busy255), .rd_count(rdc255), .wr_count(wrc255));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One burst on the LATENCY=4 instance; hold keeps the request through TURN.
  task automatic burst(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [3:0][63:0] wd, input logic hold,
                       output logic [3:0][63:0] rdv, output int lat);
    rdv = '0;
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!resp4 && lat < 400);
    if (!resp4) begin
      check("resp_timeout", 64'(resp4), 64'd1);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      return;
    end
    for (int b = 0; b < 4; b++) begin
      if (b > 0) check($sformatf("resp_beat%0d", b), 64'(resp4), 64'd1);
      rdv[b]    = rdata4;
      mem_wdata = wd[b];
      if (b < 3) tick();
    end
    tick();
    check("turn_resp", 64'(resp4), 64'd0);
    if (!hold) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
    tick();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  logic [3:0][63:0] line_a, line_junk, line_old, line_new, r, none;
  int lat, f4, f1, f255, n;

  initial begin
    line_a    = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_junk = {4{64'hDEAD_BEEF_0BAD_F00D}};
    line_old  = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                 64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    line_new  = {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2,
                 64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0};
    none      = '0;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;

    tick(); tick();
    check("rst_resp",  64'(resp4), 64'd0);
    check("rst_rdata", rdata4, 64'd0);
    check("rst_busy",  64'(busy4), 64'd0);
    check("rst_rdcnt", 64'(rdc4), 64'd0);
    check("rst_wrcnt", 64'(wrc4), 64'd0);
    rst = 1'b0;

    // Latency extremes, all instances see the same request.
    mem_addr = 32'h0000_0040;
    mem_read = 1'b1;
    f4 = 0; f1 = 0; f255 = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (resp4 && f4 == 0) f4 = i;
      if (resp1 && f1 == 0) f1 = i;
      if (resp255 && f255 == 0) f255 = i;
    end
    check("lat4_first",   64'(f4),   64'd4);
    check("lat1_first",   64'(f1),   64'd1);
    check("lat255_first", 64'(f255), 64'd255);
    mem_read = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;

    // Write then read back.
    burst(1'b0, 1'b1, 32'h0000_1040, line_a, 1'b0, r, lat);
    check("wr_latency", 64'(lat), 64'd4);
    for (int b = 0; b < 4; b++) check($sformatf("wr_rdata_zero%0d", b), r[b], 64'd0);
    check("wr_count1", 64'(wrc4), 64'd1);
    check("rd_count0", 64'(rdc4), 64'd0);

    burst(1'b1, 1'b0, 32'h0000_1040, none, 1'b0, r, lat);
    check("rd_latency", 64'(lat), 64'd4);
    for (int b = 0; b < 4; b++) check($sformatf("rd1_b%0d", b), r[b], line_a[b]);
    check("rd_count1", 64'(rdc4), 64'd1);

    // Offset bits and aliased upper bits map to the same line.
    burst(1'b1, 1'b0, 32'h0000_105F, none, 1'b0, r, lat);
    for (int b = 0; b < 4; b++) check($sformatf("rd_off_b%0d", b), r[b], line_a[b]);
    burst(1'b1, 1'b0, 32'h0010_1040, none, 1'b0, r, lat);
    for (int b = 0; b < 4; b++) check($sformatf("rd_alias_b%0d", b), r[b], line_a[b]);
    check("rd_count3", 64'(rdc4), 64'd3);

    // Read wins over simultaneous write; store stays unchanged.
    burst(1'b1, 1'b1, 32'h0000_1040, line_junk, 1'b0, r, lat);
    for (int b = 0; b < 4; b++) check($sformatf("rd_both_b%0d", b), r[b], line_a[b]);
    check("both_rdcnt", 64'(rdc4), 64'd4);
    check("both_wrcnt", 64'(wrc4), 64'd1);
    burst(1'b1, 1'b0, 32'h0000_1040, none, 1'b0, r, lat);
    for (int b = 0; b < 4; b++) check($sformatf("rd_after_both_b%0d", b), r[b], line_a[b]);

    // Request held through TURN must not trigger a second burst.
    burst(1'b1, 1'b0, 32'h0000_1040, none, 1'b1, r, lat);
    tick();
    check("late_drop_busy", 64'(busy4), 64'd0);
    tick();
    check("late_drop_resp", 64'(resp4), 64'd0);
    check("late_drop_rdcnt", 64'(rdc4), 64'd6);

    // Reset during a write burst: beats 0-1 land, 2-3 keep old data.
    burst(1'b0, 1'b1, 32'h0000_2000, line_old, 1'b0, r, lat);
    check("old_wrcnt", 64'(wrc4), 64'd2);
    mem_addr  = 32'h0000_2000;
    mem_write = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!resp4 && n < 400);
    check("abort_resp_seen", 64'(resp4), 64'd1);
    mem_wdata = line_new[0];
    tick();
    mem_wdata = line_new[1];
    tick();
    rst = 1'b1;
    mem_write = 1'b0;
    mem_wdata = line_new[2];
    tick();
    rst = 1'b0;
    check("abort_busy",  64'(busy4), 64'd0);
    check("abort_resp",  64'(resp4), 64'd0);
    check("abort_wrcnt", 64'(wrc4), 64'd0);
    burst(1'b1, 1'b0, 32'h0000_2000, none, 1'b0, r, lat);
    check("abort_rd_b0", r[0], line_new[0]);
    check("abort_rd_b1", r[1], line_new[1]);
    check("abort_rd_b2", r[2], line_old[2]);
    check("abort_rd_b3", r[3], line_old[3]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
